imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory. Fetch reads words at PCOut; this block fills memory first.
//  - Takes a byte stream (valid/ready) carrying a 16-bit word count, then the program bytes.
//  - Packs each 4 bytes into one 32-bit instruction and issues one-cycle write strobes to memory.
//  - Holds the core (PC/fetch) while loading.
// PARAMETERS
//  ADDR_W      64   width of im_wr_addr; same as PCOut
//  DEPTH_WORDS 256  instruction memory capacity in 32-bit words
//  BASE_ADDR   0    byte address of first instruction written
// PORTS
//  clk          in   1       rising-edge clock, single domain
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       one-cycle pulse; begins a load; ignored unless IDLE
//  in_data      in   8       stream byte
//  in_valid     in   1       in_data valid
//  in_ready     out  1       byte accepted when in_valid & in_ready at clk edge
//  im_wr_en     out  1       one-cycle write strobe to instruction memory
//  im_wr_addr   out  ADDR_W  byte address, word aligned (BASE_ADDR + 4*index)
//  im_wr_data   out  32      instruction word
//  cpu_hold     out  1       1 = core must not advance PC (program_counter held)
//  load_done    out  1       1 = last load completed OK; sticky until next start
//  load_err     out  1       1 = last load rejected (count > DEPTH_WORDS); sticky until next start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=0, im_wr_en=0, im_wr_addr=BASE_ADDR, im_wr_data=0,
//    cpu_hold=1, load_done=0, load_err=0. Core stays held until a successful load.
//  States: IDLE -> HDR -> DATA <-> WRITE -> DONE; HDR -> SINK on error.
//  IDLE:  in_ready=0. start=1 -> HDR; clear load_done/load_err; set cpu_hold=1; reset byte index and word index.
//  HDR:   in_ready=1. Accept 2 bytes, big-endian: count[15:8] first, then count[7:0].
//         count==0 -> DONE. count>DEPTH_WORDS -> SINK with load_err=1. Otherwise -> DATA.
//  DATA:  in_ready=1. Bytes are big-endian within a word: 1st byte -> [31:24], 4th byte -> [7:0].
//         Accepting the 4th byte -> WRITE.
//  WRITE: in_ready=0 for exactly one cycle. im_wr_en=1, im_wr_addr=BASE_ADDR+4*word_idx, im_wr_data=packed word.
//         Next cycle word_idx increments.
//         word_idx+1 == count -> DONE, else -> DATA.
//         Throughput: 4 bytes per 5 cycles at best.
//  SINK:  in_ready=1. Discard count*4 bytes with no writes, then -> IDLE. cpu_hold stays 1; load_err stays 1.
//  DONE:  load_done=1, cpu_hold=0 from the cycle DONE is entered. -> IDLE the next cycle.
//         load_done and cpu_hold=0 persist in IDLE.
//  Stalls: in_valid=0 in any accepting state leaves state and counters unchanged (bubbles allowed).
//  start while not IDLE: ignored. start in the same cycle as the DONE->IDLE transition: ignored.
//  im_wr_addr arithmetic is ADDR_W wide. word_idx range is 0..DEPTH_WORDS-1, so no wrap occurs.
//  Bytes offered while IDLE/DONE are not accepted (in_ready=0).
//  Reset mid-load: immediate return to reset values. A partial word is never written.
//  Already-written words stay in memory. cpu_hold=1 until a later successful load.
//  im_wr_addr/im_wr_data hold their last values when im_wr_en=0.
// STRUCTURE
//  Shared package legv8_pkg:
//    - loader state encoding: IDLE, HDR, DATA, WRITE, SINK, DONE
//    - INSTR_W=32
//    - BYTES_PER_INSTR=4
//  Top module holds: FSM, 16-bit count register, word_idx counter, address generation.
//  One sub-module, imem_word_packer: 2-bit byte counter plus 32-bit shift register.
//    - Inputs: byte strobe, clear.
//    - Outputs: word, word_full.
// TESTING
//  1 Reset then idle 10 cycles -> cpu_hold=1, im_wr_en=0, in_ready=0, load_done=0.
//  2 start; stream 00 02 | F8 40 03 E1 | 8B 02 00 20 ->
//    - write addr 0 data F84003E1, then write addr 4 data 8B020020
//    - load_done=1, cpu_hold=0
//  3 Same stream as 2 with in_valid toggled randomly ->
//    - identical writes
//    - no accept while in_ready=0
//    - bytes never dropped or duplicated
//  4 start; header 00 00 -> DONE with zero writes, load_done=1, cpu_hold=0.
//  5 start; header 01 01 (257 > 256); stream 1028 bytes ->
//    - all bytes accepted, no im_wr_en
//    - load_err=1, cpu_hold=1, returns to IDLE
//  6 start; header 00 03; 6 data bytes; rst_n=0 ->
//    - exactly one write (addr 0), no second write
//    - outputs at reset values asynchronously
//    - second start runs a normal load

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types for the LEGv8 core slice: loader FSM encoding and instruction geometry.
package legv8_pkg;

  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_DATA,
    LD_WRITE,
    LD_SINK,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer; the word is valid the cycle after the 4th strobe.
// No backpressure of its own: word_full flags the strobe that completes a word.
module imem_word_packer
  import legv8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               byte_vld,
  input  logic [7:0]         byte_dat,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [1:0]         byte_cnt;
  logic [INSTR_W-1:0] shift_q;

  assign word      = shift_q;
  assign word_full = byte_vld && (byte_cnt == 2'(BYTES_PER_INSTR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (byte_vld) begin
      // counter wraps to 0 after the 4th byte, ready for the next word
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[INSTR_W-9:0], byte_dat};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: 16-bit BE word count then BE program bytes; one write per 5 cycles best case.
// in_ready drops for the single WRITE cycle and outside HDR/DATA/SINK; the core is held until a load succeeds.
module imem_loader
  import legv8_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               im_wr_en,
  output logic [ADDR_W-1:0]  im_wr_addr,
  output logic [INSTR_W-1:0] im_wr_data,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  ld_state_e          state, state_nxt;
  logic               accept;
  logic               hdr_idx_q;
  logic [15:0]        count_q;
  logic [15:0]        cnt_full;
  logic [15:0]        word_idx_q;
  logic [17:0]        sink_left_q;
  logic [ADDR_W-1:0]  wr_addr_cur;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [INSTR_W-1:0] last_data_q;
  logic               pk_clear;
  logic               pk_vld;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_full;

  assign in_ready    = (state == LD_HDR) || (state == LD_DATA) || (state == LD_SINK);
  assign accept      = in_valid && in_ready;
  assign pk_vld      = in_valid && (state == LD_DATA);
  assign pk_clear    = (state == LD_IDLE) && start;
  assign cnt_full    = {count_q[15:8], in_data};
  assign wr_addr_cur = BASE_ADDR + (ADDR_W'(word_idx_q) << 2);

  assign im_wr_en   = (state == LD_WRITE);
  assign im_wr_addr = im_wr_en ? wr_addr_cur : last_addr_q;
  assign im_wr_data = im_wr_en ? pk_word : last_data_q;

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .byte_vld  (pk_vld),
    .byte_dat  (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE: if (start) state_nxt = LD_HDR;
      LD_HDR: begin
        if (accept && hdr_idx_q) begin
          if (cnt_full == 16'd0)                 state_nxt = LD_DONE;
          else if ({1'b0, cnt_full} > DEPTH_LIM) state_nxt = LD_SINK;
          else                                   state_nxt = LD_DATA;
        end
      end
      LD_DATA:  if (pk_full) state_nxt = LD_WRITE;
      LD_WRITE: state_nxt = (word_idx_q + 16'd1 == count_q) ? LD_DONE : LD_DATA;
      LD_SINK:  if (accept && sink_left_q == 18'd1) state_nxt = LD_IDLE;
      LD_DONE:  state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx_q   <= 1'b0;
      count_q     <= '0;
      word_idx_q  <= '0;
      sink_left_q <= '0;
      last_addr_q <= BASE_ADDR;
      last_data_q <= '0;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (start) begin
            hdr_idx_q  <= 1'b0;
            word_idx_q <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end
        end
        LD_HDR: begin
          if (accept) begin
            if (!hdr_idx_q) begin
              count_q[15:8] <= in_data;
              hdr_idx_q     <= 1'b1;
            end else begin
              count_q     <= cnt_full;
              sink_left_q <= {cnt_full, 2'b00};
              if (state_nxt == LD_SINK) load_err <= 1'b1;
            end
          end
        end
        LD_WRITE: begin
          word_idx_q  <= word_idx_q + 16'd1;
          last_addr_q <= wr_addr_cur;
          last_data_q <= pk_word;
        end
        LD_SINK: if (accept) sink_left_q <= sink_left_q - 18'd1;
        default: ;
      endcase
      // success flags go live on the same edge that enters DONE
      if (state_nxt == LD_DONE && state != LD_DONE) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams, expected writes queued, monitor compares on im_wr_en.
module tb_imem_loader;
  import legv8_pkg::*;

  localparam int ADDR_W = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               im_wr_en;
  logic [ADDR_W-1:0]  im_wr_addr;
  logic [INSTR_W-1:0] im_wr_data;
  logic               cpu_hold;
  logic               load_done;
  logic               load_err;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  logic [ADDR_W-1:0]  exp_addr [$];
  logic [INSTR_W-1:0] exp_data [$];
  logic [7:0]         tx_q [$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(256), .BASE_ADDR('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .im_wr_data (im_wr_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && im_wr_en) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", im_wr_addr, im_wr_data);
      end else begin
        logic [ADDR_W-1:0]  ea;
        logic [INSTR_W-1:0] ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (im_wr_addr !== ea || im_wr_data !== ed) begin
          errors++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", im_wr_addr, im_wr_data, ea, ed);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input bit bubbles);
    int guard;
    if (bubbles && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      if (bubbles) in_valid = ($urandom_range(0, 1) == 1);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout byte=%h in_ready=%b", b, in_ready);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    @(negedge clk);
    acc_cnt++;
  endtask

  task automatic send_all(input bit bubbles);
    acc_cnt = 0;
    foreach (tx_q[i]) send_byte(tx_q[i], bubbles);
    in_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic load_prog2();
    tx_q = '{8'h00, 8'h02, 8'hF8, 8'h40, 8'h03, 8'hE1, 8'h8B, 8'h02, 8'h00, 8'h20};
    expect_write(64'h0, 32'hF84003E1);
    expect_write(64'h4, 32'h8B020020);
  endtask

  task automatic check_success(input string tag, input int nbytes);
    repeat (3) @(negedge clk);
    chk({tag, "_acc"}, 64'(acc_cnt), 64'(nbytes));
    chk({tag, "_pending"}, 64'(exp_addr.size()), 64'd0);
    chk({tag, "_done"}, 64'(load_done), 64'd1);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
    chk({tag, "_rdy_idle"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    // 1: reset, idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_wr_en", 64'(im_wr_en), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);
    chk("rst_addr", im_wr_addr, 64'd0);
    chk("rst_data", 64'(im_wr_data), 64'd0);

    // 2: two-word program, continuous valid
    load_prog2();
    pulse_start();
    chk("t2_rdy_hdr", 64'(in_ready), 64'd1);
    send_all(1'b0);
    check_success("t2", 10);
    chk("t2_addr_hold", im_wr_addr, 64'h4);
    chk("t2_data_hold", 64'(im_wr_data), 64'h8B020020);

    // 3: same program with bubbles; start must clear the previous done
    load_prog2();
    pulse_start();
    chk("t3_done_clr", 64'(load_done), 64'd0);
    chk("t3_hold_set", 64'(cpu_hold), 64'd1);
    send_all(1'b1);
    check_success("t3", 10);

    // 4: zero-length program
    tx_q = '{8'h00, 8'h00};
    pulse_start();
    send_all(1'b0);
    check_success("t4", 2);

    // 5: oversize count 257 is sunk without writes
    tx_q = '{8'h01, 8'h01};
    for (int i = 0; i < 1028; i++) tx_q.push_back(8'(i));
    pulse_start();
    send_all(1'b0);
    repeat (3) @(negedge clk);
    chk("t5_acc", 64'(acc_cnt), 64'd1030);
    chk("t5_err", 64'(load_err), 64'd1);
    chk("t5_hold", 64'(cpu_hold), 64'd1);
    chk("t5_done", 64'(load_done), 64'd0);
    chk("t5_rdy_idle", 64'(in_ready), 64'd0);
    chk("t5_pending", 64'(exp_addr.size()), 64'd0);

    // 6: reset in the middle of the second word
    tx_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expect_write(64'h0, 32'h11223344);
    pulse_start();
    send_all(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_hold", 64'(cpu_hold), 64'd1);
    chk("t6_rst_rdy", 64'(in_ready), 64'd0);
    chk("t6_rst_wr_en", 64'(im_wr_en), 64'd0);
    chk("t6_rst_addr", im_wr_addr, 64'd0);
    chk("t6_rst_data", 64'(im_wr_data), 64'd0);
    chk("t6_rst_err", 64'(load_err), 64'd0);
    chk("t6_pending", 64'(exp_addr.size()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    load_prog2();
    pulse_start();
    send_all(1'b0);
    check_success("t6b", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
